// File: rtl/a_logic_stage.sv
// ----------------------------------------------------------------------------
// a_logic_stage
//   Clocked bundled-data logic stage for the four-phase handshake pipeline.
//   On the capture edge it registers f(d_i) into d_o. r_o is raised T cycles
//   later. The stage waits for a_o, and then for r_i and a_o to both return
//   to idle before it drops a_i.
//
// Parameters
//   N     data width (1..1024)
//   T     cycles from capture edge to r_o assertion (1..255)
//   Rpol  idle level of r_i, a_i, r_o and a_o; the active level is ~Rpol
//   OP    0 NOT, 1 BUF, 2 XOR K, 3 AND K, 4 OR K; any other value acts as NOT
//   K     constant operand for OP 2..4
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active high
//   r_i   in   upstream request
//   a_i   out  upstream acknowledge (registered)
//   d_i   in   upstream data, valid while r_i is active
//   r_o   out  downstream request (registered)
//   a_o   in   downstream acknowledge
//   d_o   out  downstream data (registered, changes only on capture or reset)
//   busy  out  high whenever the stage is not idle
// ----------------------------------------------------------------------------
module a_logic_stage #(
    parameter int unsigned N    = 32'd1,
    parameter int unsigned T    = 32'd2,
    parameter bit          Rpol = 1'b0,
    parameter int unsigned OP   = 32'd0,
    parameter logic [N-1:0] K   = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StDelay, StReq, StRtz} state_e;

    localparam logic [7:0] TCnt = 8'(T);

    state_e       r_state;
    state_e       w_state_next;
    logic [7:0]   r_count;
    logic [7:0]   w_count_next;
    logic         r_a_i;
    logic         r_r_o;
    logic [N-1:0] r_d_o;

    logic         w_req;
    logic         w_ack;
    logic         w_capture;
    logic         w_a_i_act;
    logic         w_r_o_act;
    logic [N-1:0] w_f;

    // Polarity-normalised handshake inputs: 1 means "active".
    assign w_req = (r_i != Rpol);
    assign w_ack = (a_o != Rpol);

    // Bitwise transform selected at elaboration time.
    always_comb begin
        case (OP)
            32'd1:   w_f = d_i;
            32'd2:   w_f = d_i ^ K;
            32'd3:   w_f = d_i & K;
            32'd4:   w_f = d_i | K;
            default: w_f = ~d_i;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_count <= 8'd0;
            r_a_i   <= Rpol;
            r_r_o   <= Rpol;
            r_d_o   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_a_i   <= w_a_i_act ? ~Rpol : Rpol;
            r_r_o   <= w_r_o_act ? ~Rpol : Rpol;
            if (w_capture) begin
                r_d_o <= w_f;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_next = StDelay;
                    w_count_next = TCnt;
                end
            end
            StDelay: begin
                w_count_next = r_count - 8'd1;
                // count==1 on this edge makes r_o active exactly T edges after capture
                if (r_count == 8'd1) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (w_ack) begin
                    w_state_next = StRtz;
                end
            end
            StRtz: begin
                // a_i is only released once both neighbours are back to idle
                if (!w_req && !w_ack) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode. a_i/r_o are registered from the next state so they
    // leave the flops glitch-free and line up with the state change.
    always_comb begin
        w_capture = (r_state == StIdle) && w_req;
        w_a_i_act = (w_state_next != StIdle);
        w_r_o_act = (w_state_next == StReq);
        busy      = (r_state != StIdle);
    end

    assign a_i = r_a_i;
    assign r_o = r_r_o;
    assign d_o = r_d_o;

endmodule
